// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC block.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned LEN_W            = 16;
  localparam int unsigned BYTE_W           = 8;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/student_crc_byte.sv
// Combinational CRC update over one byte, MSB first, non-reflected polynomial.
module student_crc_byte
  import crc_pkg::*;
#(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] POLY = W'(CRC8_POLY)
) (
  input  logic [W-1:0]      crc_in,
  input  logic [BYTE_W-1:0] data,
  output logic [W-1:0]      crc_next
);

  logic [W-1:0] w_crc;
  logic         w_fb;

  // Eight serial shift steps unrolled into one cycle.
  always_comb begin
    w_crc = crc_in;
    w_fb  = 1'b0;
    for (int i = BYTE_W - 1; i >= 0; i--) begin
      w_fb  = w_crc[W-1] ^ data[i];
      w_crc = w_crc << 1;
      if (w_fb) begin
        w_crc = w_crc ^ POLY;
      end
    end
    crc_next = w_crc;
  end

endmodule

// File: rtl/student_crc.sv
// Streaming byte-wide CRC engine with start/last framing and a held result.
module student_crc
  import crc_pkg::*;
#(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] POLY = W'(CRC8_POLY),
  parameter logic [W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      crc_out,
  output logic [LEN_W-1:0]  len_out
);

  state_t           r_state;
  logic [W-1:0]     r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;

  state_t           w_state_next;
  logic [W-1:0]     w_crc_next;
  logic [LEN_W-1:0] w_len_next;
  logic [W-1:0]     w_byte_crc;
  logic             w_accept;

  student_crc_byte #(
    .W    (W),
    .POLY (POLY)
  ) u_byte (
    .crc_in   (r_crc),
    .data     (in_data),
    .crc_next (w_byte_crc)
  );

  // A start in RUN wins over a beat presented in the same cycle.
  assign in_ready = (r_state == RUN) && !start;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_crc_next   = r_crc;
    w_len_next   = r_len;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_crc_next   = INIT;
          w_len_next   = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (start) begin
          w_crc_next = INIT;
          w_len_next = '0;
        end else if (w_accept) begin
          w_crc_next = w_byte_crc;
          w_len_next = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);
          if (in_last) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_len       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_crc       <= w_crc_next;
      r_len       <= w_len_next;
      r_out_valid <= (w_state_next == DONE);
    end
  end

  assign out_valid = r_out_valid;
  assign crc_out   = r_crc;
  assign len_out   = r_len;

endmodule

// File: tb/tb_student_crc.sv
// Directed table-driven bench for student_crc: CRC-8 and CRC-16/CCITT instances share stimulus.
module tb_student_crc;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        rdy8, rdy16, ov8, ov16;
  logic [7:0]  crc8;
  logic [15:0] crc16, len8, len16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  student_crc u8 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .crc_out(crc8), .len_out(len8)
  );

  student_crc #(.W(16), .POLY(16'h1021), .INIT(16'hFFFF)) u16 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy16),
    .in_data(in_data), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
    .crc_out(crc16), .len_out(len16)
  );

  typedef struct {
    logic        rst, st, iv;
    logic [7:0]  d;
    logic        last, ordy;
    logic        e_rdy, e_ov;
    logic [15:0] e_len;
    logic        c8;
    logic [7:0]  e8;
    logic        c16;
    logic [15:0] e16;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic st, input logic iv,
                              input logic [7:0] d, input logic last, input logic ordy,
                              input logic e_rdy, input logic e_ov, input logic [15:0] e_len,
                              input logic c8, input logic [7:0] e8,
                              input logic c16, input logic [15:0] e16, input string tag);
    vec_t v;
    v.rst = rst; v.st = st; v.iv = iv; v.d = d; v.last = last; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_len = e_len;
    v.c8 = c8; v.e8 = e8; v.c16 = c16; v.e16 = e16; v.tag = tag;
    tbl.push_back(v);
  endfunction

  // Drive on the falling edge, check in_ready before the rising edge, registered outputs after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; start = v.st; in_valid = v.iv; in_data = v.d;
    in_last = v.last; out_ready = v.ordy;
    #1;
    chk($sformatf("%s[%0d].in_ready", v.tag, idx), 32'(rdy8), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d].out_valid", v.tag, idx), 32'(ov8), 32'(v.e_ov));
    chk($sformatf("%s[%0d].len_out", v.tag, idx), 32'(len8), 32'(v.e_len));
    if (v.c8) chk($sformatf("%s[%0d].crc8", v.tag, idx), 32'(crc8), 32'(v.e8));
    if (v.c16) begin
      chk($sformatf("%s[%0d].crc16", v.tag, idx), 32'(crc16), 32'(v.e16));
      chk($sformatf("%s[%0d].len16", v.tag, idx), 32'(len16), 32'(v.e_len));
      chk($sformatf("%s[%0d].ov16", v.tag, idx), 32'(ov16), 32'(v.e_ov));
    end
  endtask

  initial begin
    // A: "123456789" back-to-back on both widths, then release and ignored IDLE beat.
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 1,16'hFFFF, "std_start");
    for (int i = 0; i < 9; i++)
      add(0,0,1,8'(8'h31 + i),(i == 8),0, 1,(i == 8),16'(i + 1),
          (i == 0) || (i == 8), (i == 0) ? 8'h97 : 8'hF4, (i == 8), 16'h29B1, "std_byte");
    add(0,0,0,8'h00,0,1, 0,0,16'd9, 1,8'hF4, 1,16'h29B1, "std_release");
    add(0,0,1,8'h55,0,0, 0,0,16'd9, 1,8'hF4, 1,16'h29B1, "idle_ignore");

    // B: single byte 0x01, result held while out_ready is low; start and in_valid ignored in DONE.
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 0,16'h0, "one_start");
    add(0,0,1,8'h01,1,0, 1,1,16'd1, 1,8'h07, 0,16'h0, "one_byte");
    for (int i = 0; i < 5; i++)
      add(0,1,1,8'hA5,1,0, 0,1,16'd1, 1,8'h07, 0,16'h0, "one_hold");
    add(0,0,0,8'h00,0,1, 0,0,16'd1, 1,8'h07, 0,16'h0, "one_release");

    // C: restart mid-message with a beat presented on the start cycle.
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 0,16'h0, "rst_msg_start");
    add(0,0,1,8'h31,0,0, 1,0,16'd1, 1,8'h97, 0,16'h0, "rst_msg_b1");
    add(0,0,1,8'h32,0,0, 1,0,16'd2, 1,8'h72, 0,16'h0, "rst_msg_b2");
    add(0,1,1,8'h33,0,0, 0,0,16'd0, 1,8'h00, 1,16'hFFFF, "restart");
    for (int i = 0; i < 9; i++)
      add(0,0,1,8'(8'h31 + i),(i == 8),0, 1,(i == 8),16'(i + 1),
          (i == 8), 8'hF4, (i == 8), 16'h29B1, "restart_byte");
    add(0,0,0,8'h00,0,1, 0,0,16'd9, 1,8'hF4, 0,16'h0, "restart_release");

    // D: in_valid toggling; gap cycles carry junk that must not be taken.
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 0,16'h0, "gap_start");
    for (int i = 0; i < 9; i++) begin
      add(0,0,1,8'(8'h31 + i),(i == 8),0, 1,(i == 8),16'(i + 1),
          (i == 0) || (i == 8), (i == 0) ? 8'h97 : 8'hF4, (i == 8), 16'h29B1, "gap_byte");
      if (i < 8)
        add(0,0,0,8'hAA,1,0, 1,0,16'(i + 1), (i == 0), 8'h97, 0,16'h0, "gap_idle");
    end
    add(0,0,0,8'h00,0,1, 0,0,16'd9, 1,8'hF4, 0,16'h0, "gap_release");

    // E: reset in RUN after 3 bytes, then in_valid without start; then reset in DONE.
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 0,16'h0, "mid_start");
    add(0,0,1,8'h31,0,0, 1,0,16'd1, 1,8'h97, 0,16'h0, "mid_b");
    add(0,0,1,8'h32,0,0, 1,0,16'd2, 1,8'h72, 0,16'h0, "mid_b");
    add(0,0,1,8'h33,0,0, 1,0,16'd3, 0,8'h00, 0,16'h0, "mid_b");
    add(1,0,1,8'h34,0,0, 1,0,16'd0, 1,8'h00, 1,16'hFFFF, "mid_reset");
    add(0,0,1,8'h35,0,0, 0,0,16'd0, 1,8'h00, 1,16'hFFFF, "post_reset_ign");
    add(0,0,1,8'h36,1,0, 0,0,16'd0, 1,8'h00, 1,16'hFFFF, "post_reset_ign");
    add(0,1,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 0,16'h0, "done_start");
    add(0,0,1,8'h01,1,0, 1,1,16'd1, 1,8'h07, 0,16'h0, "done_byte");
    add(1,0,0,8'h00,0,0, 0,0,16'd0, 1,8'h00, 1,16'hFFFF, "done_reset");
    add(0,0,0,8'h00,0,1, 0,0,16'd0, 1,8'h00, 0,16'h0, "done_after");

    // Power-on reset and reset-state checks.
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(rdy8), 32'd0);
    chk("reset.out_valid", 32'(ov8), 32'd0);
    chk("reset.len_out", 32'(len8), 32'd0);
    chk("reset.crc8", 32'(crc8), 32'h00);
    chk("reset.crc16", 32'(crc16), 32'hFFFF);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Length counter saturation over a very long message.
    @(negedge clk);
    reset = 1'b0; start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat.len_at_max", 32'(len8), 32'hFFFF);
    chk("sat.out_valid", 32'(ov8), 32'd0);
    @(posedge clk);
    #1;
    chk("sat.len_held", 32'(len8), 32'hFFFF);
    @(negedge clk);
    in_last = 1'b1;
    @(posedge clk);
    #1;
    chk("sat.last_ov", 32'(ov8), 32'd1);
    chk("sat.last_len", 32'(len8), 32'hFFFF);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sat.release_ov", 32'(ov8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/student_crc.md
STUDENT_CRC -- requirements
Module: student_crc

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning CRC width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter POLY, default 8'h07, meaning W-bit generator polynomial (non-reflected, implicit x^W term).
REQ-003 The block SHALL have parameter INIT, default 0, meaning W-bit value loaded into the CRC register on start.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-005 Ports SHALL be, in order:
  clk        in   1   rising-edge clock
  reset      in   1   synchronous active-high reset
  start      in   1   begin a new message, loads INIT
  in_valid   in   1   in_data/in_last valid
  in_ready   out  1   block accepts a beat this cycle
  in_data    in   8   message byte, MSB processed first
  in_last    in   1   final byte of message
  out_valid  out  1   crc_out/len_out hold a finished result
  out_ready  in   1   consumer takes the result
  crc_out    out  W   running or final CRC register
  len_out    out  16  bytes accepted in current message, saturating

Function
REQ-006 States SHALL be IDLE, RUN and DONE.
REQ-007 in_ready SHALL equal (state==RUN) and not start, combinationally.
REQ-008 A beat SHALL be accepted only in a cycle with in_valid and in_ready both high.
REQ-009 On an accepted beat, crc_out SHALL update next cycle to the CRC after processing all 8 bits, MSB first: fb = crc[W-1]^bit; crc = crc<<1 truncated to W bits; if fb, crc ^= POLY.
REQ-010 The throughput SHALL be one byte per cycle with no bubbles.
REQ-011 len_out SHALL increment by 1 on each accepted beat and saturate at 16'hFFFF.
REQ-012 In IDLE, start SHALL set crc_out=INIT and len_out=0 and move to RUN next cycle.
REQ-013 In RUN, start SHALL restart the message: crc_out=INIT and len_out=0; any beat presented that cycle is not accepted.
REQ-014 An accepted beat with in_last=1 SHALL move to DONE; out_valid SHALL be 1 in the following cycle, with crc_out including that byte.
REQ-015 In DONE, out_valid=1 and crc_out/len_out SHALL be held stable until a cycle with out_ready=1, then go to IDLE next cycle.
REQ-016 In DONE, start SHALL be ignored.
REQ-017 in_valid in IDLE or DONE SHALL be ignored, with no state change.
REQ-018 out_valid SHALL be 0 in IDLE and RUN.
REQ-019 In IDLE, crc_out and len_out SHALL retain their last values.

Reset
REQ-020 reset SHALL take priority over all inputs; next cycle state=IDLE, crc_out=INIT, len_out=0, out_valid=0, in_ready=0.
REQ-021 Reset asserted mid-message (RUN or DONE) SHALL discard the partial or unread result with no out_valid pulse.

Structure
REQ-022 The shared package crc_pkg SHALL hold the state enum and constants CRC8_POLY=8'h07 and CRC16_CCITT_POLY=16'h1021.
REQ-023 The combinational byte update SHALL live in sub-module student_crc_byte (parameters W and POLY; ports crc_in, data, crc_next), instantiated once.

Verification
REQ-024 The bench SHALL cover W=8, POLY=8'h07, INIT=0: start, then bytes 0x31..0x39 back-to-back, last on 0x39 -> out_valid=1, crc_out=8'hF4, len_out=9.
REQ-025 The bench SHALL cover W=16, POLY=16'h1021, INIT=16'hFFFF: same 9 bytes -> crc_out=16'h29B1, len_out=9.
REQ-026 The bench SHALL cover W=8, single byte 0x01 with in_last -> crc_out=8'h07 one cycle after acceptance; out_ready held low 5 cycles -> crc_out stays 8'h07 and out_valid stays 1.
REQ-027 The bench SHALL cover W=8: bytes 0x31,0x32, then start with in_valid=1, then 0x31..0x39 -> in_ready=0 on the start cycle and final crc_out=8'hF4, len_out=9.
REQ-028 The bench SHALL cover reset asserted in RUN after 3 bytes -> next cycle crc_out=INIT, len_out=0, out_valid=0; in_valid with no start is then ignored.
REQ-029 The bench SHALL cover in_valid toggling 1,0,1,... across 0x31..0x39 -> same result 8'hF4 and len_out=9.
